// File: rtl/elbeth_pkg.sv
// Shared definitions for the elbeth pipeline controller: trap cause codes,
// next-PC mux encodings, data access sizes and the data-port FSM states.
package elbeth_pkg;

    // Trap cause codes reported on except_cause.
    localparam int unsigned CAUSE_FETCH_TIMEOUT = 1;
    localparam int unsigned CAUSE_MISALIGN      = 4;
    localparam int unsigned CAUSE_DATA_TIMEOUT  = 5;

    // Next-PC mux selection.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_TRAP   = 2'd2
    } pc_sel_t;

    // Data access size on dmem_size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } dmem_size_t;

    // Data-port FSM state encoding.
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_WAIT = 2'd1,
        DS_ERR  = 2'd2
    } dmem_state_t;

    // A half access must be 2-byte aligned, a word access 4-byte aligned.
    // Bytes and the unused size code are never misaligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == SIZE_HALF) begin
            bad = addr_lo[0];
        end else if (size == SIZE_WORD) begin
            bad = (addr_lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/elbeth_watchdog.sv
// Saturating cycle counter used to time out an outstanding memory request.
// expired stays high while the count sits at TIMEOUT; clr has priority.
module elbeth_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_en,
    input  logic clr,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count;

    // Count waiting cycles, holding at the limit instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (cnt_en && (count != LIMIT)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/elbeth_pipe_ctrl.sv
// Pipeline control for the elbeth core: per-stage stall/flush, PC hold and
// next-PC select, trap generation with one recovery cycle, and retire.
// Define ELBETH_PIPE_CTRL_WATCHDOG_EN to build the imem/dmem watchdogs and
// the data-port ERR state; without it a memory wait stalls indefinitely.
//
// Handshake: a memory request is outstanding while its *_en is high and
// its *_ready is low; the cycle *_ready is high the access completes and
// no stall is raised for it.
module elbeth_pipe_ctrl
    import elbeth_pkg::*;
#(
    parameter int STAGES  = 3,
    parameter int TIMEOUT = 16,
    parameter int CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               imem_en,
    input  logic               imem_ready,
    input  logic               dmem_en,
    input  logic               dmem_ready,
    input  logic [1:0]         dmem_addr_lo,
    input  logic [1:0]         dmem_size,
    input  logic               id_load_use,
    input  logic               id_branch_taken,
    input  logic               exs_exception,
    input  logic [CAUSE_W-1:0] exs_cause,
    output logic [STAGES-1:0]  stall,
    output logic [STAGES-1:0]  flush,
    output logic               pc_stall,
    output logic [1:0]         pc_select,
    output logic               except_valid,
    output logic [CAUSE_W-1:0] except_cause,
    output logic               retire,
    output dmem_state_t        dmem_state
);

    localparam logic [STAGES-1:0] ALL_STAGES = {STAGES{1'b1}};
    // IF and ID (bits 0 and 1).
    localparam logic [STAGES-1:0] FRONT_PAIR = STAGES'(2'b11);
    // Stage 2 receives the load-use bubble; absent in a two-stage pipe.
    localparam logic [STAGES-1:0] BUBBLE_STG = STAGES'(3'b100);

    // Out-of-range parameters leave this marker block in the hierarchy.
    if ((STAGES < 2) || (STAGES > 5) || (TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_illegal_params
    end

    dmem_state_t        state_q;
    logic               recovery_q;

    logic               misalign;
    logic               dmem_req_new;
    logic               dmem_launch;
    logic               dmem_wait_pending;
    logic               imem_pending;
    logic               mem_stall;
    logic               imem_timeout;
    logic               dmem_timeout;
    logic               dmem_wd_expired;
    logic               trap_req;
    logic               trap_fire;
    logic [CAUSE_W-1:0] trap_cause;

    logic [STAGES-1:0]  stall_raw;
    logic [STAGES-1:0]  stall_c;
    logic [STAGES-1:0]  flush_c;
    logic               pc_stall_c;
    logic [1:0]         pc_select_c;
    logic               except_c;

    // Alignment is only judged when a new access is presented in IDLE.
    assign misalign          = dmem_en && (state_q == DS_IDLE) &&
                               is_misaligned(dmem_size, dmem_addr_lo);
    assign dmem_req_new      = dmem_en && !dmem_ready && !misalign &&
                               (state_q == DS_IDLE);
    // A flushed EXS access never launches.
    assign dmem_launch       = dmem_req_new && !trap_fire;
    assign dmem_wait_pending = (state_q == DS_WAIT) && !dmem_ready;
    assign imem_pending      = imem_en && !imem_ready;
    assign mem_stall         = imem_pending || dmem_req_new || dmem_wait_pending;

`ifdef ELBETH_PIPE_CTRL_WATCHDOG_EN
    logic imem_wd_en;
    logic imem_wd_clr;
    logic dmem_wd_en;
    logic dmem_wd_clr;

    // A trap flushes IF, so the fetch in flight is dropped with it.
    assign imem_wd_en  = imem_pending;
    assign imem_wd_clr = !imem_pending || trap_fire;
    // The launch cycle counts, so ERR follows TIMEOUT-1 full WAIT cycles
    // plus the expiry cycle.
    assign dmem_wd_en  = dmem_launch || dmem_wait_pending;
    assign dmem_wd_clr = !dmem_wd_en;

    elbeth_watchdog #(.TIMEOUT(TIMEOUT)) u_imem_wd (
        .clk     (clk),
        .rst_n   (rst),
        .cnt_en  (imem_wd_en),
        .clr     (imem_wd_clr),
        .expired (imem_timeout)
    );

    elbeth_watchdog #(.TIMEOUT(TIMEOUT)) u_dmem_wd (
        .clk     (clk),
        .rst_n   (rst),
        .cnt_en  (dmem_wd_en),
        .clr     (dmem_wd_clr),
        .expired (dmem_wd_expired)
    );

    assign dmem_timeout = (state_q == DS_ERR);
`else
    assign imem_timeout    = 1'b0;
    assign dmem_wd_expired = 1'b0;
    assign dmem_timeout    = 1'b0;
`endif

    assign trap_req  = exs_exception || misalign || dmem_timeout || imem_timeout;
    assign trap_fire = trap_req && !recovery_q;

    // Pick the winning trap cause: exception, misalign, data, fetch timeout.
    always_comb begin
        trap_cause = '0;
        if (exs_exception) begin
            trap_cause = exs_cause;
        end else if (misalign) begin
            trap_cause = CAUSE_W'(CAUSE_MISALIGN);
        end else if (dmem_timeout) begin
            trap_cause = CAUSE_W'(CAUSE_DATA_TIMEOUT);
        end else if (imem_timeout) begin
            trap_cause = CAUSE_W'(CAUSE_FETCH_TIMEOUT);
        end
    end

    // Pipeline control decode: trap > memory stall > branch > load-use.
    always_comb begin
        stall_raw   = '0;
        flush_c     = '0;
        pc_stall_c  = 1'b0;
        pc_select_c = PC_SEQ;
        except_c    = 1'b0;
        if (trap_fire) begin
            flush_c     = ALL_STAGES;
            pc_select_c = PC_TRAP;
            except_c    = 1'b1;
        end else if (mem_stall) begin
            stall_raw  = ALL_STAGES;
            pc_stall_c = 1'b1;
        end else if (id_branch_taken) begin
            pc_select_c = PC_BRANCH;
            flush_c     = FRONT_PAIR;
        end else if (id_load_use) begin
            pc_stall_c = 1'b1;
            stall_raw  = FRONT_PAIR;
            flush_c    = BUBBLE_STG;
        end
    end

    // A flushed stage never also holds.
    assign stall_c = stall_raw & ~flush_c;

    // Data-port FSM: IDLE -> WAIT on an accepted unready access, back on ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DS_IDLE;
        end else begin
            case (state_q)
                DS_IDLE: begin
                    if (dmem_launch) begin
                        state_q <= DS_WAIT;
                    end
                end
                DS_WAIT: begin
                    if (dmem_ready) begin
                        state_q <= DS_IDLE;
                    end else if (dmem_wd_expired) begin
                        state_q <= DS_ERR;
                    end
                end
`ifdef ELBETH_PIPE_CTRL_WATCHDOG_EN
                DS_ERR: begin
                    state_q <= DS_IDLE;
                end
`endif
                default: begin
                    state_q <= DS_IDLE;
                end
            endcase
        end
    end

    // Trap bookkeeping and retire: recovery window, held cause, retire pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            recovery_q   <= 1'b0;
            except_cause <= '0;
            retire       <= 1'b0;
        end else begin
            recovery_q <= trap_fire;
            retire     <= !stall_c[STAGES-1] && !flush_c[STAGES-1] && !trap_fire;
            if (trap_fire) begin
                except_cause <= trap_cause;
            end
        end
    end

    // Combinational outputs are forced low for the whole reset interval.
    assign stall        = rst ? stall_c     : '0;
    assign flush        = rst ? flush_c     : '0;
    assign pc_stall     = rst ? pc_stall_c  : 1'b0;
    assign pc_select    = rst ? pc_select_c : 2'b00;
    assign except_valid = rst ? except_c    : 1'b0;
    assign dmem_state   = state_q;

endmodule

// File: tb/tb_elbeth_pipe_ctrl.sv
// Directed bench for elbeth_pipe_ctrl (STAGES=3, TIMEOUT=4, CAUSE_W=4).
// Watchdog checks follow ELBETH_PIPE_CTRL_WATCHDOG_EN, matching the RTL build.
module tb_elbeth_pipe_ctrl;
    import elbeth_pkg::*;

    localparam int STAGES  = 3;
    localparam int TIMEOUT = 4;
    localparam int CAUSE_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               imem_en;
    logic               imem_ready;
    logic               dmem_en;
    logic               dmem_ready;
    logic [1:0]         dmem_addr_lo;
    logic [1:0]         dmem_size;
    logic               id_load_use;
    logic               id_branch_taken;
    logic               exs_exception;
    logic [CAUSE_W-1:0] exs_cause;
    logic [STAGES-1:0]  stall;
    logic [STAGES-1:0]  flush;
    logic               pc_stall;
    logic [1:0]         pc_select;
    logic               except_valid;
    logic [CAUSE_W-1:0] except_cause;
    logic               retire;
    dmem_state_t        dmem_state;

    int errors = 0;
    int checks = 0;

    elbeth_pipe_ctrl #(
        .STAGES  (STAGES),
        .TIMEOUT (TIMEOUT),
        .CAUSE_W (CAUSE_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_en         (imem_en),
        .imem_ready      (imem_ready),
        .dmem_en         (dmem_en),
        .dmem_ready      (dmem_ready),
        .dmem_addr_lo    (dmem_addr_lo),
        .dmem_size       (dmem_size),
        .id_load_use     (id_load_use),
        .id_branch_taken (id_branch_taken),
        .exs_exception   (exs_exception),
        .exs_cause       (exs_cause),
        .stall           (stall),
        .flush           (flush),
        .pc_stall        (pc_stall),
        .pc_select       (pc_select),
        .except_valid    (except_valid),
        .except_cause    (except_cause),
        .retire          (retire),
        .dmem_state      (dmem_state)
    );

    // Clock: posedges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Safety net in case the sequence ever stops advancing.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        imem_en         = 1'b0;
        imem_ready      = 1'b1;
        dmem_en         = 1'b0;
        dmem_ready      = 1'b0;
        dmem_addr_lo    = 2'd0;
        dmem_size       = SIZE_WORD;
        id_load_use     = 1'b0;
        id_branch_taken = 1'b0;
        exs_exception   = 1'b0;
        exs_cause       = '0;
    endtask

    task automatic drive_dmem(input logic [1:0] size, input logic [1:0] addr, input logic rdy);
        dmem_en      = 1'b1;
        dmem_size    = size;
        dmem_addr_lo = addr;
        dmem_ready   = rdy;
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge where outputs are sampled.
    task automatic settle();
        #4;
    endtask

    initial begin
        // ---------------- reset with every input active ----------------
        rst = 1'b0;
        drive_idle();
        imem_en = 1'b1; imem_ready = 1'b0; exs_exception = 1'b1; exs_cause = 4'd3;
        drive_dmem(SIZE_WORD, 2'd2, 1'b0);
        id_load_use = 1'b1; id_branch_taken = 1'b1;
        #12;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_pc_stall", 32'(pc_stall), 32'd0);
        check("rst_pc_select", 32'(pc_select), 32'd0);
        check("rst_except_valid", 32'(except_valid), 32'd0);
        check("rst_except_cause", 32'(except_cause), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_state", 32'(dmem_state), 32'(DS_IDLE));
        drive_idle();
        @(negedge clk);
        rst = 1'b1;

        next_cycle(); drive_idle(); settle();
        check("idle_retire", 32'(retire), 32'd1);
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_flush", 32'(flush), 32'd0);

        // ---------------- data memory stall, ready after 3 cycles ----------------
        next_cycle(); drive_dmem(SIZE_WORD, 2'd0, 1'b0); settle();
        check("dstall0_stall", 32'(stall), 32'h7);
        check("dstall0_pc_stall", 32'(pc_stall), 32'd1);
        check("dstall0_except", 32'(except_valid), 32'd0);
        check("dstall0_flush", 32'(flush), 32'd0);
        next_cycle(); settle();
        check("dstall1_stall", 32'(stall), 32'h7);
        check("dstall1_state", 32'(dmem_state), 32'(DS_WAIT));
        check("dstall1_retire", 32'(retire), 32'd0);
        next_cycle(); settle();
        check("dstall2_stall", 32'(stall), 32'h7);
        check("dstall2_except", 32'(except_valid), 32'd0);
        next_cycle(); dmem_ready = 1'b1; settle();
        check("dready_stall", 32'(stall), 32'd0);
        check("dready_pc_stall", 32'(pc_stall), 32'd0);
        next_cycle(); drive_idle(); settle();
        check("dafter_state", 32'(dmem_state), 32'(DS_IDLE));
        check("dafter_retire", 32'(retire), 32'd1);

        // ---------------- misaligned word access ----------------
        next_cycle(); drive_dmem(SIZE_WORD, 2'd2, 1'b0); settle();
        check("mis_except", 32'(except_valid), 32'd1);
        check("mis_pc_select", 32'(pc_select), 32'(PC_TRAP));
        check("mis_flush", 32'(flush), 32'h7);
        check("mis_stall", 32'(stall), 32'd0);
        check("mis_pc_stall", 32'(pc_stall), 32'd0);
        // recovery cycle: a new exception is ignored
        next_cycle(); drive_idle(); exs_exception = 1'b1; exs_cause = 4'd7; settle();
        check("recov_except", 32'(except_valid), 32'd0);
        check("recov_pc_select", 32'(pc_select), 32'(PC_SEQ));
        check("recov_flush", 32'(flush), 32'd0);
        check("mis_cause", 32'(except_cause), 32'd4);
        check("mis_state", 32'(dmem_state), 32'(DS_IDLE));
        check("mis_retire", 32'(retire), 32'd0);
        next_cycle(); drive_idle(); settle();
        check("recov_cause_held", 32'(except_cause), 32'd4);
        check("recov_retire", 32'(retire), 32'd1);
        // byte at addr 3 is aligned
        next_cycle(); drive_dmem(SIZE_BYTE, 2'd3, 1'b1); settle();
        check("byte3_except", 32'(except_valid), 32'd0);
        check("byte3_stall", 32'(stall), 32'd0);
        // half at addr 1 is misaligned
        next_cycle(); drive_dmem(SIZE_HALF, 2'd1, 1'b0); settle();
        check("half1_except", 32'(except_valid), 32'd1);
        check("half1_flush", 32'(flush), 32'h7);
        next_cycle(); drive_idle(); settle();
        check("half1_cause", 32'(except_cause), 32'd4);
        check("half1_state", 32'(dmem_state), 32'(DS_IDLE));

        // ---------------- exception beats misalign ----------------
        next_cycle(); drive_dmem(SIZE_WORD, 2'd1, 1'b0); exs_exception = 1'b1; exs_cause = 4'd2; settle();
        check("prio_except", 32'(except_valid), 32'd1);
        check("prio_pc_select", 32'(pc_select), 32'(PC_TRAP));
        next_cycle(); drive_idle(); settle();
        check("prio_cause", 32'(except_cause), 32'd2);
        check("prio_state", 32'(dmem_state), 32'(DS_IDLE));

        // ---------------- branch and load-use ----------------
        next_cycle(); drive_idle(); id_load_use = 1'b1; id_branch_taken = 1'b1; settle();
        check("brlu_pc_select", 32'(pc_select), 32'(PC_BRANCH));
        check("brlu_flush", 32'(flush), 32'h3);
        check("brlu_stall", 32'(stall), 32'd0);
        check("brlu_pc_stall", 32'(pc_stall), 32'd0);
        next_cycle(); drive_idle(); id_load_use = 1'b1; settle();
        check("lu_pc_stall", 32'(pc_stall), 32'd1);
        check("lu_stall", 32'(stall), 32'h3);
        check("lu_flush", 32'(flush), 32'h4);
        check("lu_pc_select", 32'(pc_select), 32'(PC_SEQ));
        next_cycle(); drive_idle(); id_branch_taken = 1'b1; settle();
        check("br_pc_select", 32'(pc_select), 32'(PC_BRANCH));
        check("br_flush", 32'(flush), 32'h3);
        check("lu_retire", 32'(retire), 32'd0);
        next_cycle(); drive_idle(); settle();
        check("br_retire", 32'(retire), 32'd1);

        // ---------------- memory stall beats branch and load-use ----------------
        next_cycle(); drive_idle(); imem_en = 1'b1; imem_ready = 1'b0;
        id_load_use = 1'b1; id_branch_taken = 1'b1; settle();
        check("istall_stall", 32'(stall), 32'h7);
        check("istall_pc_stall", 32'(pc_stall), 32'd1);
        check("istall_flush", 32'(flush), 32'd0);
        check("istall_pc_select", 32'(pc_select), 32'(PC_SEQ));
        // trap beats the memory stall
        next_cycle(); id_load_use = 1'b0; id_branch_taken = 1'b0;
        exs_exception = 1'b1; exs_cause = 4'd9; settle();
        check("trapstall_except", 32'(except_valid), 32'd1);
        check("trapstall_stall", 32'(stall), 32'd0);
        check("trapstall_flush", 32'(flush), 32'h7);
        check("trapstall_pc_select", 32'(pc_select), 32'(PC_TRAP));
        next_cycle(); drive_idle(); settle();
        check("trapstall_cause", 32'(except_cause), 32'd9);
        check("trapstall_recov", 32'(except_valid), 32'd0);
        next_cycle(); drive_idle(); settle();

`ifdef ELBETH_PIPE_CTRL_WATCHDOG_EN
        // ---------------- data timeout: ERR after 4 WAIT cycles ----------------
        next_cycle(); drive_dmem(SIZE_WORD, 2'd0, 1'b0); settle();
        check("dto_launch_stall", 32'(stall), 32'h7);
        for (int i = 1; i <= 4; i++) begin
            next_cycle(); settle();
            check("dto_wait_state", 32'(dmem_state), 32'(DS_WAIT));
            check("dto_wait_except", 32'(except_valid), 32'd0);
        end
        next_cycle(); dmem_en = 1'b0; settle();
        check("dto_err_state", 32'(dmem_state), 32'(DS_ERR));
        check("dto_err_except", 32'(except_valid), 32'd1);
        check("dto_err_pc_select", 32'(pc_select), 32'(PC_TRAP));
        check("dto_err_flush", 32'(flush), 32'h7);
        next_cycle(); drive_idle(); settle();
        check("dto_cause", 32'(except_cause), 32'd5);
        check("dto_idle_state", 32'(dmem_state), 32'(DS_IDLE));
        next_cycle(); drive_idle(); settle();

        // ---------------- fetch timeout ----------------
        next_cycle(); imem_en = 1'b1; imem_ready = 1'b0; settle();
        check("ito_c0_except", 32'(except_valid), 32'd0);
        next_cycle(); settle();
        check("ito_c1_stall", 32'(stall), 32'h7);
        next_cycle(); settle();
        next_cycle(); settle();
        check("ito_c3_except", 32'(except_valid), 32'd0);
        next_cycle(); settle();
        check("ito_c4_except", 32'(except_valid), 32'd1);
        check("ito_c4_pc_select", 32'(pc_select), 32'(PC_TRAP));
        next_cycle(); drive_idle(); settle();
        check("ito_cause", 32'(except_cause), 32'd1);
        next_cycle(); drive_idle(); settle();
`else
        // ---------------- no watchdog: wait stalls with no trap ----------------
        next_cycle(); drive_dmem(SIZE_WORD, 2'd0, 1'b0); settle();
        for (int i = 0; i < 100; i++) begin
            next_cycle(); settle();
            check("nowd_hold", {28'd0, except_valid, stall}, 32'h7);
        end
        next_cycle(); dmem_ready = 1'b1; settle();
        check("nowd_release_stall", 32'(stall), 32'd0);
        next_cycle(); drive_idle(); settle();
        check("nowd_state", 32'(dmem_state), 32'(DS_IDLE));
`endif

        // ---------------- reset in the middle of WAIT ----------------
        next_cycle(); drive_dmem(SIZE_WORD, 2'd0, 1'b0); settle();
        next_cycle(); settle();
        check("rwait_state", 32'(dmem_state), 32'(DS_WAIT));
        #1 rst = 1'b0;
        #1;
        check("rwait_stall", 32'(stall), 32'd0);
        check("rwait_pc_stall", 32'(pc_stall), 32'd0);
        check("rwait_except", 32'(except_valid), 32'd0);
        check("rwait_cause", 32'(except_cause), 32'd0);
        check("rwait_state_rst", 32'(dmem_state), 32'(DS_IDLE));
        check("rwait_retire", 32'(retire), 32'd0);
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        next_cycle(); drive_idle(); settle();
        check("rwait_post_state", 32'(dmem_state), 32'(DS_IDLE));
        check("rwait_post_except", 32'(except_valid), 32'd0);
        check("rwait_post_retire", 32'(retire), 32'd1);
        next_cycle(); drive_dmem(SIZE_WORD, 2'd0, 1'b1); settle();
        check("rwait_post_stall", 32'(stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
